uart_tx_arbiter: RTL and testbench

//  Shares one UART transmit line among NUM_REQ byte requesters. Round-robin arbitration with

---
 rtl/uart_pkg.sv | 41 ++++
 rtl/uart_rr_arbiter.sv | 26 ++
 rtl/uart_tx_arbiter.sv | 156 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit arbiter: FSM state encoding
// and the round-robin pick function used by uart_rr_arbiter.
package uart_pkg;

    localparam int UART_MAX_REQ       = 8;
    localparam int UART_MAX_DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_t;

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } rr_pick_t;

    // Lowest cyclic offset from ptr wins; scanning offsets downward lets it overwrite.
    function automatic rr_pick_t rr_pick(input logic [UART_MAX_REQ-1:0] valid,
                                         input logic [2:0]              ptr,
                                         input int                      num_req);
        rr_pick_t   pick;
        logic [2:0] k;
        pick = '0;
        for (int off = UART_MAX_REQ - 1; off >= 0; off--) begin
            if (off < num_req) begin
                k = 3'((int'(ptr) + off) % num_req);
                if (valid[k]) begin
                    pick.found = 1'b1;
                    pick.idx   = k;
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/uart_rr_arbiter.sv
// Combinational round-robin arbiter: request vector plus priority pointer in,
// one-hot grant and granted index out. The pointer register lives in the parent.
module uart_rr_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] i_valid,
    input  logic [ID_W-1:0]    i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [ID_W-1:0]    o_idx,
    output logic               o_any
);

    rr_pick_t w_pick;

    always_comb begin
        w_pick = rr_pick(UART_MAX_REQ'(i_valid), 3'(i_ptr), NUM_REQ);
    end

    assign o_any   = w_pick.found;
    assign o_idx   = ID_W'(w_pick.idx);
    assign o_grant = w_pick.found ? (NUM_REQ'(1) << w_pick.idx) : '0;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-locking arbiter that serializes requester bytes onto one UART tx line.
// Optional even-parity bit when UART_TX_ARB_PARITY_EN is defined.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter  int NUM_REQ   = 4,
    parameter  int DATA_BITS = 8,
    parameter  int STOP_BITS = 1,
    localparam int ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                         system_clk,
    input  logic                         reset,
    input  logic                         txclk_en,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*DATA_BITS-1:0] req_data,
    input  logic [NUM_REQ-1:0]           req_last,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic [ID_W-1:0]              grant_id,
    output logic                         busy,
    output logic                         txd
);

    uart_state_t          r_state, w_state_next;
    logic [2:0]           r_bit_cnt, w_cnt_next;
    logic [ID_W-1:0]      r_ptr, r_grant_id, w_idx, w_ptr_next;
    logic                 r_lock, r_txclk_en_q;
    logic                 w_tick, w_any, w_accept, w_txd;
    logic [NUM_REQ-1:0]   w_cand_valid, w_grant, w_owner_mask;
    logic [DATA_BITS-1:0] r_shift, w_sel_data;
`ifdef UART_TX_ARB_PARITY_EN
    logic                 r_parity;
`endif

    // Each edge of the baud toggle marks one bit period.
    assign w_tick       = txclk_en ^ r_txclk_en_q;
    assign w_owner_mask = NUM_REQ'(1) << r_grant_id;
    assign w_cand_valid = r_lock ? (req_valid & w_owner_mask) : req_valid;

    uart_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_arbiter (
        .i_valid (w_cand_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    assign w_accept   = reset && (r_state == IDLE) && w_any;
    assign w_sel_data = req_data[w_idx*DATA_BITS +: DATA_BITS];
    assign w_ptr_next = (w_idx == ID_W'(NUM_REQ - 1)) ? '0 : ID_W'(w_idx + 1'b1);

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_bit_cnt;
        w_txd        = 1'b1;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_next = SYNC;
                    w_cnt_next   = '0;
                end
            end
            SYNC: begin
                if (w_tick) w_state_next = START;
            end
            START: begin
                w_txd = 1'b0;
                if (w_tick) begin
                    w_state_next = DATA;
                    w_cnt_next   = '0;
                end
            end
            DATA: begin
                w_txd = r_shift[0];
                if (w_tick) begin
                    if (r_bit_cnt == 3'(DATA_BITS - 1)) begin
`ifdef UART_TX_ARB_PARITY_EN
                        w_state_next = PARITY;
`else
                        w_state_next = STOP;
`endif
                        w_cnt_next   = '0;
                    end else begin
                        w_cnt_next = r_bit_cnt + 3'd1;
                    end
                end
            end
`ifdef UART_TX_ARB_PARITY_EN
            PARITY: begin
                w_txd = r_parity;
                if (w_tick) begin
                    w_state_next = STOP;
                    w_cnt_next   = '0;
                end
            end
`endif
            STOP: begin
                // The final stop period is completed by SYNC, so back-to-back frames need no idle bit.
                if (r_bit_cnt == 3'(STOP_BITS - 1)) begin
                    w_state_next = IDLE;
                    w_cnt_next   = '0;
                end else if (w_tick) begin
                    w_cnt_next = r_bit_cnt + 3'd1;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge system_clk) begin
        r_txclk_en_q <= txclk_en;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge system_clk) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_bit_cnt  <= '0;
            r_ptr      <= '0;
            r_lock     <= 1'b0;
            r_grant_id <= '0;
        end else begin
            r_state   <= w_state_next;
            r_bit_cnt <= w_cnt_next;
            if (w_accept) begin
                r_grant_id <= w_idx;
                r_ptr      <= w_ptr_next;
                r_lock     <= ~req_last[w_idx];
            end
        end
    end

    // NOTE: datapath registers carry no reset; they are always loaded before the FSM reads them.
    always_ff @(posedge system_clk) begin
        if (w_accept) begin
            r_shift <= w_sel_data;
        end else if ((r_state == DATA) && w_tick) begin
            r_shift <= r_shift >> 1;
        end
    end

`ifdef UART_TX_ARB_PARITY_EN
    always_ff @(posedge system_clk) begin
        if (w_accept) r_parity <= ^w_sel_data;
    end
`endif

    assign req_ready = w_accept ? w_grant : '0;
    assign grant_id  = r_grant_id;
    assign busy      = (r_state != IDLE) || r_lock;
    assign txd       = w_txd;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized self-checking bench for uart_tx_arbiter: arbitration model, serial
// receiver model and directed reset/lock/stall scenarios (parity with UART_TX_ARB_PARITY_EN).
module tb_uart_tx_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;
    localparam int ID_W      = 2;
    localparam int TICK_DIV  = 8;
`ifdef UART_TX_ARB_PARITY_EN
    localparam int PAR_BITS  = 1;
`else
    localparam int PAR_BITS  = 0;
`endif
    localparam int FRAME_LEN = 1 + DATA_BITS + PAR_BITS + STOP_BITS;

    logic                         system_clk = 1'b0;
    logic                         reset      = 1'b0;
    logic                         txclk_en   = 1'b0;
    logic [NUM_REQ-1:0]           req_valid  = '0;
    logic [NUM_REQ*DATA_BITS-1:0] req_data   = '0;
    logic [NUM_REQ-1:0]           req_last   = '0;
    logic [NUM_REQ-1:0]           req_ready;
    logic [ID_W-1:0]              grant_id;
    logic                         busy;
    logic                         txd;

    uart_tx_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .DATA_BITS (DATA_BITS),
        .STOP_BITS (STOP_BITS)
    ) dut (
        .system_clk (system_clk),
        .reset      (reset),
        .txclk_en   (txclk_en),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_last   (req_last),
        .req_ready  (req_ready),
        .grant_id   (grant_id),
        .busy       (busy),
        .txd        (txd)
    );

    always #5 system_clk = ~system_clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        logic [7:0] data;
        logic       last;
    } item_t;

    item_t      rq[NUM_REQ][$];
    logic [7:0] exp_q[$];
    int         order_q[$];
    int         rdy_cycles[NUM_REQ];
    int         m_ptr = 0, m_owner = 0, gid_exp = 0;
    bit         m_lock = 0, gid_pending = 0, rand_hold = 0;

    // Receiver-side state
    event        tick_ev;
    int          rx_cnt = 0, idle_run = 0, gaps = 0, frames = 0;
    logic [15:0] rx_bits = '0, last_frame = '0;
    logic        last_parity = 1'b0;

    function automatic int model_pick(input logic [NUM_REQ-1:0] v);
        for (int o = 0; o < NUM_REQ; o++) begin
            int k;
            k = (m_ptr + o) % NUM_REQ;
            if (v[k] && (!m_lock || k == m_owner)) return k;
        end
        return -1;
    endfunction

    function automatic logic [15:0] frame_of(input logic [7:0] b);
        logic [15:0] f;
        f = '0;
        for (int j = 0; j < DATA_BITS; j++) f[1+j] = b[j];
        if (PAR_BITS == 1) f[1+DATA_BITS] = ^b;
        for (int s = 0; s < STOP_BITS; s++) f[1+DATA_BITS+PAR_BITS+s] = 1'b1;
        return f;
    endfunction

    function automatic bit all_empty();
        for (int i = 0; i < NUM_REQ; i++) if (rq[i].size() != 0) return 0;
        return 1;
    endfunction

    task automatic monitor();
        int                 e, dut_idx;
        logic [NUM_REQ-1:0] exp_oh;
        if (!reset) begin
            m_ptr = 0; m_lock = 0; m_owner = 0; gid_pending = 0;
            return;
        end
        if (gid_pending) begin
            check("grant_id", 32'(grant_id), 32'(gid_exp));
            check("busy_after_accept", 32'(busy), 1);
            gid_pending = 0;
        end
        for (int i = 0; i < NUM_REQ; i++) if (req_ready[i]) rdy_cycles[i]++;
        if (req_ready !== '0) begin
            e      = model_pick(req_valid);
            exp_oh = (e >= 0) ? (NUM_REQ'(1) << e) : '0;
            check("req_ready", 32'(req_ready), 32'(exp_oh));
            dut_idx = -1;
            for (int i = NUM_REQ - 1; i >= 0; i--) if (req_ready[i]) dut_idx = i;
            order_q.push_back(dut_idx);
            if (e >= 0) begin
                exp_q.push_back(rq[e][0].data);
                m_lock  = !rq[e][0].last;
                m_owner = e;
                m_ptr   = (e + 1) % NUM_REQ;
                void'(rq[e].pop_front());
                gid_exp     = e;
                gid_pending = 1;
            end
        end
    endtask

    task automatic finish_frame();
        logic [7:0] b;
        logic       stop_ok;
        b = '0;
        for (int j = 0; j < DATA_BITS; j++) b[j] = rx_bits[1+j];
        last_frame = rx_bits;
        if (exp_q.size() == 0) check("rx_unexpected_frame", 1, 0);
        else                   check("rx_byte", 32'(b), 32'(exp_q.pop_front()));
        if (PAR_BITS == 1) begin
            last_parity = rx_bits[1+DATA_BITS];
            check("rx_parity", 32'(last_parity), 32'(^b));
        end
        stop_ok = 1'b1;
        for (int s = 0; s < STOP_BITS; s++)
            if (rx_bits[1+DATA_BITS+PAR_BITS+s] !== 1'b1) stop_ok = 1'b0;
        check("rx_stop", 32'(stop_ok), 1);
    endtask

    // Baud toggle source
    initial begin
        forever begin
            repeat (TICK_DIV) @(posedge system_clk);
            #1 txclk_en = ~txclk_en;
            -> tick_ev;
        end
    end

    // Line receiver: one sample near the middle of each bit period
    initial begin
        forever begin
            @(tick_ev);
            repeat (5) @(negedge system_clk);
            if (rx_cnt == 0) begin
                if (txd === 1'b0) begin
                    if (frames > 0 && idle_run > 0) gaps++;
                    idle_run = 0;
                    rx_bits  = '0;
                    rx_cnt   = 1;
                end else begin
                    idle_run++;
                end
            end else begin
                rx_bits[rx_cnt] = txd;
                rx_cnt++;
                if (rx_cnt == FRAME_LEN) begin
                    rx_cnt = 0;
                    frames++;
                    finish_frame();
                end
            end
        end
    end

    // Requester driver and acceptance monitor
    initial begin
        forever begin
            @(posedge system_clk);
            #1;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (rq[i].size() > 0 && !(rand_hold && $urandom_range(3) == 0)) begin
                    req_valid[i]                         = 1'b1;
                    req_data[i*DATA_BITS +: DATA_BITS]   = rq[i][0].data;
                    req_last[i]                          = rq[i][0].last;
                end else begin
                    req_valid[i] = 1'b0;
                end
            end
            @(negedge system_clk);
            monitor();
        end
    end

    task automatic drain(input string tag, input int max_cycles);
        int c;
        c = 0;
        while (!(all_empty() && exp_q.size() == 0 && rx_cnt == 0 && busy == 1'b0)
               && c < max_cycles) begin
            @(negedge system_clk);
            c++;
        end
        check(tag, 32'(c < max_cycles), 1);
    endtask

    task automatic check_order(input string tag, input int exp[$]);
        check({tag, "_count"}, 32'(order_q.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < order_q.size(); i++)
            check(tag, 32'(order_q[i]), 32'(exp[i]));
    endtask

    task automatic quick_reset();
        @(posedge system_clk); #2 reset = 1'b0;
        repeat (2) @(posedge system_clk);
        #2 reset = 1'b1;
    endtask

    initial begin
        int eo[$];
        int c;
        item_t it;

        // Reset values
        repeat (3) @(negedge system_clk);
        check("rst_txd", 32'(txd), 1);
        check("rst_ready", 32'(req_ready), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_grant_id", 32'(grant_id), 0);
        @(posedge system_clk); #2 reset = 1'b1;

        // Single byte 0x55: frame 0,1,0,1,0,1,0,1,0,1 (plus parity bit when enabled)
        for (int i = 0; i < NUM_REQ; i++) rdy_cycles[i] = 0;
        rq[0].push_back('{8'h55, 1'b1});
        drain("single_drain", 4000);
        check("single_frame", 32'(last_frame), 32'(frame_of(8'h55)));
        check("single_ready_cycles", 32'(rdy_cycles[0]), 1);

        // Reset in the middle of a locked frame
        rq[2].push_back('{8'h3C, 1'b0});
        c = 0;
        while (rx_cnt < 4 && c < 4000) begin @(negedge system_clk); c++; end
        check("midframe_reached", 32'(c < 4000), 1);
        rq[0].push_back('{8'h81, 1'b1});
        @(posedge system_clk); #2 reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge system_clk);
            rx_cnt = 0;
            exp_q.delete();
            @(negedge system_clk);
            check("rstmid_txd", 32'(txd), 1);
            check("rstmid_ready", 32'(req_ready), 0);
            check("rstmid_busy", 32'(busy), 0);
            check("rstmid_grant_id", 32'(grant_id), 0);
        end
        @(posedge system_clk); #2 reset = 1'b1;
        drain("rstmid_drain", 4000);

        // Round-robin with everyone valid
        quick_reset();
        order_q.delete(); frames = 0; gaps = 0;
        rq[0].push_back('{8'hA0, 1'b1});
        rq[0].push_back('{8'hA0, 1'b1});
        for (int i = 1; i < NUM_REQ; i++) begin
            it.data = 8'(8'hA0 + i);
            it.last = 1'b1;
            rq[i].push_back(it);
        end
        drain("rr_drain", 8000);
        eo = '{0, 1, 2, 3, 0};
        check_order("rr_order", eo);
        check("rr_gaps", 32'(gaps), 0);

        // Message lock: req1 owns the line for two bytes
        order_q.delete();
        rq[1].push_back('{8'h11, 1'b0});
        rq[1].push_back('{8'h22, 1'b1});
        rq[0].push_back('{8'h30, 1'b1});
        rq[2].push_back('{8'h32, 1'b1});
        drain("lock_drain", 8000);
        eo = '{1, 1, 2, 0};
        check_order("lock_order", eo);

        // Owner stalls mid-message for 40 bit periods
        order_q.delete();
        rq[3].push_back('{8'h5A, 1'b0});
        rq[0].push_back('{8'h0F, 1'b1});
        c = 0;
        while (!(order_q.size() == 1 && exp_q.size() == 0 && rx_cnt == 0) && c < 4000) begin
            @(negedge system_clk); c++;
        end
        check("stall_first_done", 32'(c < 4000), 1);
        for (int t = 0; t < 40; t++) begin
            repeat (TICK_DIV) @(negedge system_clk);
            check("stall_txd", 32'(txd), 1);
            check("stall_busy", 32'(busy), 1);
            check("stall_ready", 32'(req_ready), 0);
        end
        rq[3].push_back('{8'hC3, 1'b1});
        drain("stall_drain", 4000);
        eo = '{3, 3, 0};
        check_order("stall_order", eo);

`ifdef UART_TX_ARB_PARITY_EN
        rq[0].push_back('{8'h07, 1'b1});
        drain("par07_drain", 4000);
        check("parity_07", 32'(last_parity), 1);
        rq[0].push_back('{8'h03, 1'b1});
        drain("par03_drain", 4000);
        check("parity_03", 32'(last_parity), 0);
`endif

        // Randomized traffic with random valid gaps and message lengths
        rand_hold = 1;
        for (int i = 0; i < NUM_REQ; i++) begin
            int n;
            n = $urandom_range(6, 3);
            for (int j = 0; j < n; j++) begin
                it.data = 8'($urandom);
                it.last = (j == n - 1) ? 1'b1 : ($urandom_range(2) == 0);
                rq[i].push_back(it);
            end
        end
        drain("rand_drain", 40000);
        rand_hold = 0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
